// File: rtl/ucsbece154b_perf_monitor_if.sv
// Control, sampled pipeline signals and readout of the performance monitor.
// master drives the pipeline side; slave is the monitor itself.
interface ucsbece154b_perf_monitor_if #(
   parameter int LANES = 2,
   parameter int CNT_W = 32
);
   logic                  enable;
   logic                  clear;
   logic [LANES*32-1:0]   instrF;
   logic [LANES*32-1:0]   pcF;
   logic [LANES*32-1:0]   instrD;
   logic [LANES*7-1:0]    opE;
   logic [LANES-1:0]      mispredictE;
   logic [LANES-1:0]      takenF;
   logic [2:0]            rd_sel;
   logic [CNT_W-1:0]      rd_data;
   logic [1:0]            state;
   logic                  done;
   logic                  timeout;

   modport master (
      output enable, clear, instrF, pcF, instrD,
      output opE, mispredictE, takenF, rd_sel,
      input  rd_data, state, done, timeout
   );

   modport slave (
      input  enable, clear, instrF, pcF, instrD,
      input  opE, mispredictE, takenF, rd_sel,
      output rd_data, state, done, timeout
   );
endinterface

// File: rtl/ucsbece154b_perf_monitor.sv
// Multi-lane pipeline performance monitor: saturating event counters,
// idle-loop halt detection, cycle-budget timeout and registered readout.
module ucsbece154b_perf_monitor #(
   parameter int          LANES      = 2,
   parameter int          CNT_W      = 32,
   parameter int          MAX_CYCLES = 500,
   parameter logic [31:0] NOP        = 32'h00000013
) (
   input logic clk,
   input logic reset,
   ucsbece154b_perf_monitor_if.slave bus
);

   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;
   localparam int         CW      = (CNT_W > 32) ? CNT_W : 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t               state_q;
   logic                 done_q;
   logic                 timeout_q;
   logic                 prev_valid;
   logic [LANES*32-1:0]  prev_pc;
   logic [CNT_W-1:0]     cyc_q, ins_q, br_q, brm_q, jmp_q, jmpm_q;
   logic [CNT_W-1:0]     rd_q, rd_nx, cyc_nx;
   logic [2:0]           n_ins, n_br, n_brm, n_jmp, n_jmpm;
   logic                 all_nop, halt, to_hit;

   function automatic logic [CNT_W-1:0] sat_add(
      input logic [CNT_W-1:0] a,
      input logic [2:0]       b
   );
      logic [CNT_W+2:0] s;
      s = (CNT_W+3)'(a) + (CNT_W+3)'(b);
      if (s > (CNT_W+3)'({CNT_W{1'b1}}))
         return {CNT_W{1'b1}};
      return s[CNT_W-1:0];
   endfunction

   // Per-lane event tallies, summed so every lane lands in the same cycle.
   always_comb begin
      n_ins   = 3'd0;
      n_br    = 3'd0;
      n_brm   = 3'd0;
      n_jmp   = 3'd0;
      n_jmpm  = 3'd0;
      all_nop = 1'b1;
      for (int l = 0; l < LANES; l++) begin
         if (bus.instrD[l*32 +: 32] != 32'd0 &&
             bus.instrD[l*32 +: 32] != NOP)
            n_ins = n_ins + 3'd1;
         if (bus.opE[l*7 +: 7] == OP_BR) begin
            n_br = n_br + 3'd1;
            if (bus.mispredictE[l])
               n_brm = n_brm + 3'd1;
         end
         if (bus.opE[l*7 +: 7] == OP_JAL ||
             bus.opE[l*7 +: 7] == OP_JALR) begin
            n_jmp = n_jmp + 3'd1;
            if (!bus.takenF[l])
               n_jmpm = n_jmpm + 3'd1;
         end
         if (bus.instrF[l*32 +: 32] != NOP)
            all_nop = 1'b0;
      end
   end

   // A core spinning on NOPs at a fixed PC has finished its program.
   assign halt   = prev_valid & all_nop & (bus.pcF == prev_pc);
   assign cyc_nx = sat_add(cyc_q, 3'd1);
   assign to_hit = CW'(cyc_nx) == CW'(MAX_CYCLES);

   always_comb begin
      rd_nx = '0;
      case (bus.rd_sel)
         3'd0:    rd_nx = cyc_q;
         3'd1:    rd_nx = ins_q;
         3'd2:    rd_nx = br_q;
         3'd3:    rd_nx = brm_q;
         3'd4:    rd_nx = jmp_q;
         3'd5:    rd_nx = jmpm_q;
         default: rd_nx = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset || bus.clear) begin
         state_q    <= IDLE;
         done_q     <= 1'b0;
         timeout_q  <= 1'b0;
         prev_valid <= 1'b0;
         prev_pc    <= '0;
         cyc_q      <= '0;
         ins_q      <= '0;
         br_q       <= '0;
         brm_q      <= '0;
         jmp_q      <= '0;
         jmpm_q     <= '0;
         rd_q       <= '0;
      end else begin
         rd_q <= rd_nx;
         unique case (state_q)
            IDLE: begin
               if (bus.enable)
                  state_q <= RUN;
            end
            RUN: begin
               cyc_q      <= cyc_nx;
               br_q       <= sat_add(br_q, n_br);
               brm_q      <= sat_add(brm_q, n_brm);
               jmp_q      <= sat_add(jmp_q, n_jmp);
               jmpm_q     <= sat_add(jmpm_q, n_jmpm);
               prev_pc    <= bus.pcF;
               prev_valid <= 1'b1;
               if (!halt)
                  ins_q <= sat_add(ins_q, n_ins);
               // Halt outranks a coincident budget expiry.
               if (halt) begin
                  state_q <= HALTED;
                  done_q  <= 1'b1;
               end else if (to_hit) begin
                  state_q   <= HALTED;
                  done_q    <= 1'b1;
                  timeout_q <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.rd_data = rd_q;
   assign bus.state   = state_q;
   assign bus.done    = done_q;
   assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_ucsbece154b_perf_monitor.sv
// Bench for the perf monitor: three parameterisations on shared stimulus,
// directed scenarios plus random traffic against a behavioural model.
module tb_ucsbece154b_perf_monitor;

   localparam logic [31:0] NOP     = 32'h00000013;
   localparam logic [31:0] ADDI    = 32'h00100093;
   localparam logic [6:0]  OP_BR   = 7'b1100011;
   localparam logic [6:0]  OP_JAL  = 7'b1101111;
   localparam logic [6:0]  OP_JALR = 7'b1100111;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic        clear = 1'b0;
   logic [2:0]  rd_sel = 3'd0;
   logic [63:0] instrF = '0;
   logic [63:0] pcF = '0;
   logic [63:0] instrD = '0;
   logic [13:0] opE = '0;
   logic [1:0]  misp = '0;
   logic [1:0]  taken = '0;

   int n_chk = 0;
   int n_fail = 0;

   int          mst[3];
   bit          mdone[3], mto[3], mpv[3];
   logic [31:0] mppc[3][2];
   longint      mcnt[3][6];
   longint      mrd[3];
   longint      mmax[3] = '{64'hFFFFFFFF, 64'hFFFFFFFF, 64'd15};
   longint      mlim[3] = '{500, 8, 500};

   ucsbece154b_perf_monitor_if #(.LANES(2), .CNT_W(32)) b0();
   ucsbece154b_perf_monitor_if #(.LANES(2), .CNT_W(32)) b1();
   ucsbece154b_perf_monitor_if #(.LANES(2), .CNT_W(4))  b2();

   assign {b0.enable, b0.clear, b0.rd_sel, b0.instrF, b0.pcF, b0.instrD,
           b0.opE, b0.mispredictE, b0.takenF} =
          {enable, clear, rd_sel, instrF, pcF, instrD, opE, misp, taken};
   assign {b1.enable, b1.clear, b1.rd_sel, b1.instrF, b1.pcF, b1.instrD,
           b1.opE, b1.mispredictE, b1.takenF} =
          {enable, clear, rd_sel, instrF, pcF, instrD, opE, misp, taken};
   assign {b2.enable, b2.clear, b2.rd_sel, b2.instrF, b2.pcF, b2.instrD,
           b2.opE, b2.mispredictE, b2.takenF} =
          {enable, clear, rd_sel, instrF, pcF, instrD, opE, misp, taken};

   ucsbece154b_perf_monitor #(.LANES(2)) u0 (
      .clk(clk), .reset(reset), .bus(b0));
   ucsbece154b_perf_monitor #(.LANES(2), .MAX_CYCLES(8)) u1 (
      .clk(clk), .reset(reset), .bus(b1));
   ucsbece154b_perf_monitor #(.LANES(2), .CNT_W(4)) u2 (
      .clk(clk), .reset(reset), .bus(b2));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic longint sat(input longint v, input int k);
      return (v > mmax[k]) ? mmax[k] : v;
   endfunction

   // Reference: what each monitor must do at the coming edge.
   task automatic model();
      for (int k = 0; k < 3; k++) begin
         if (reset || clear) begin
            mst[k] = 0; mdone[k] = 0; mto[k] = 0; mpv[k] = 0;
            mppc[k][0] = 0; mppc[k][1] = 0; mrd[k] = 0;
            for (int c = 0; c < 6; c++) mcnt[k][c] = 0;
         end else begin
            mrd[k] = (rd_sel < 6) ? mcnt[k][rd_sel] : 0;
            if (mst[k] == 0) begin
               if (enable) mst[k] = 1;
            end else if (mst[k] == 1) begin
               bit halt;
               int ni, nb, nbm, nj, njm;
               halt = mpv[k];
               ni = 0; nb = 0; nbm = 0; nj = 0; njm = 0;
               for (int l = 0; l < 2; l++) begin
                  logic [31:0] f, d, p;
                  logic [6:0]  o;
                  f = instrF[l*32 +: 32];
                  d = instrD[l*32 +: 32];
                  p = pcF[l*32 +: 32];
                  o = opE[l*7 +: 7];
                  if (f != NOP || p != mppc[k][l]) halt = 0;
                  if (d != 0 && d != NOP) ni++;
                  if (o == OP_BR) begin nb++; if (misp[l]) nbm++; end
                  if (o == OP_JAL || o == OP_JALR) begin
                     nj++;
                     if (!taken[l]) njm++;
                  end
                  mppc[k][l] = p;
               end
               mpv[k] = 1;
               mcnt[k][0] = sat(mcnt[k][0] + 1, k);
               if (!halt) mcnt[k][1] = sat(mcnt[k][1] + ni, k);
               mcnt[k][2] = sat(mcnt[k][2] + nb, k);
               mcnt[k][3] = sat(mcnt[k][3] + nbm, k);
               mcnt[k][4] = sat(mcnt[k][4] + nj, k);
               mcnt[k][5] = sat(mcnt[k][5] + njm, k);
               if (halt) begin
                  mst[k] = 2; mdone[k] = 1;
               end else if (mcnt[k][0] == mlim[k]) begin
                  mst[k] = 2; mdone[k] = 1; mto[k] = 1;
               end
            end
         end
      end
   endtask

   task automatic compare();
      logic [63:0] g_st[3], g_dn[3], g_to[3], g_rd[3];
      g_st[0] = 64'(b0.state);   g_st[1] = 64'(b1.state);
      g_st[2] = 64'(b2.state);
      g_dn[0] = 64'(b0.done);    g_dn[1] = 64'(b1.done);
      g_dn[2] = 64'(b2.done);
      g_to[0] = 64'(b0.timeout); g_to[1] = 64'(b1.timeout);
      g_to[2] = 64'(b2.timeout);
      g_rd[0] = 64'(b0.rd_data); g_rd[1] = 64'(b1.rd_data);
      g_rd[2] = 64'(b2.rd_data);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("u%0d.state", k), g_st[k], 64'(mst[k]));
         check($sformatf("u%0d.done", k), g_dn[k], 64'(mdone[k]));
         check($sformatf("u%0d.timeout", k), g_to[k], 64'(mto[k]));
         check($sformatf("u%0d.rd_data", k), g_rd[k], 64'(mrd[k]));
      end
   endtask

   task automatic step();
      model();
      @(posedge clk);
      #1;
      compare();
   endtask

   function automatic logic [31:0] rnd_instr();
      return ($urandom & 32'hFFFFFF00) | 32'h00000033;
   endfunction

   task automatic busy(input int i);
      instrF = {rnd_instr(), rnd_instr()};
      pcF    = {32'h1004 + 32'(i*8), 32'h1000 + 32'(i*8)};
   endtask

   task automatic spin();
      instrF = {NOP, NOP};
      pcF    = {32'h44, 32'h40};
   endtask

   logic [63:0] expB[6];

   initial begin
      expB[0] = 6; expB[1] = 0; expB[2] = 2;
      expB[3] = 1; expB[4] = 3; expB[5] = 3;

      step(); step();
      reset = 1'b0;
      step();

      // 10 cycles of two ADDIs per cycle, then park on a NOP loop.
      enable = 1'b1; step(); enable = 1'b0;
      instrD = {ADDI, ADDI}; taken = 2'b11;
      for (int i = 1; i <= 10; i++) begin busy(i); step(); end
      spin(); instrD = '0; rd_sel = 3'd0; step();
      check("A.cycles", 64'(b0.rd_data), 10);
      rd_sel = 3'd1; step();
      check("A.instrs", 64'(b0.rd_data), 20);
      check("A.halted", 64'(b0.state), 2);
      for (int s = 2; s < 6; s++) begin
         rd_sel = 3'(s); step();
         check($sformatf("A.sel%0d", s), 64'(b0.rd_data), 0);
      end

      // Branches, jumps, then a NOP loop at 0x40/0x44 from cycle 5.
      clear = 1'b1; step(); clear = 1'b0;
      enable = 1'b1; step(); enable = 1'b0;
      instrD = '0; busy(20);
      opE = {OP_BR, OP_BR}; misp = 2'b01; step();
      opE = {OP_JAL, 7'h00}; misp = 2'b00; taken = 2'b01;
      for (int i = 0; i < 3; i++) begin busy(30 + i); step(); end
      opE = '0; spin(); step(); step();
      check("B.state", 64'(b0.state), 2);
      check("B.done", 64'(b0.done), 1);
      check("B.timeout", 64'(b0.timeout), 0);
      instrD = {ADDI, ADDI}; opE = {OP_BR, OP_JALR}; busy(40);
      for (int s = 0; s < 6; s++) begin
         rd_sel = 3'(s); step();
         check($sformatf("B.sel%0d", s), 64'(b0.rd_data), expB[s]);
      end

      // Cycle budget of 8 on u1; clear beats a simultaneous enable.
      clear = 1'b1; enable = 1'b1; step(); clear = 1'b0;
      step(); enable = 1'b0;
      for (int i = 0; i < 8; i++) begin
         busy(50 + i); opE = 14'($urandom); step();
      end
      check("C.state", 64'(b1.state), 2);
      check("C.timeout", 64'(b1.timeout), 1);
      rd_sel = 3'd0; step();
      check("C.cycles", 64'(b1.rd_data), 8);
      clear = 1'b1; step(); clear = 1'b0;
      check("C.clr_state", 64'(b1.state), 0);
      check("C.clr_timeout", 64'(b1.timeout), 0);
      check("C.clr_rd", 64'(b1.rd_data), 0);
      for (int s = 0; s < 6; s++) begin
         rd_sel = 3'(s); step();
         check($sformatf("C.clr_sel%0d", s), 64'(b1.rd_data), 0);
      end

      // 20 cycles of two instructions saturate the 4-bit counters.
      enable = 1'b1; step(); enable = 1'b0;
      instrD = {ADDI, ADDI}; opE = '0;
      for (int i = 0; i < 20; i++) begin busy(60 + i); step(); end
      rd_sel = 3'd0; step();
      check("D.cycles_sat", 64'(b2.rd_data), 15);
      rd_sel = 3'd1; step();
      check("D.instrs_sat", 64'(b2.rd_data), 15);

      // Random traffic biased towards NOP loops and frequent re-arming.
      for (int i = 0; i < 2000; i++) begin
         reset  = ($urandom_range(0, 99) == 0);
         clear  = ($urandom_range(0, 39) == 0);
         enable = ($urandom_range(0, 2) == 0);
         rd_sel = 3'($urandom_range(0, 7));
         for (int l = 0; l < 2; l++) begin
            instrF[l*32 +: 32] = ($urandom_range(0, 3) != 0) ? NOP
                                                            : rnd_instr();
            pcF[l*32 +: 32] = $urandom_range(0, 1) ? 32'h40 : 32'h44;
            case ($urandom_range(0, 3))
               0: instrD[l*32 +: 32] = 32'd0;
               1: instrD[l*32 +: 32] = NOP;
               2: instrD[l*32 +: 32] = ADDI;
               default: instrD[l*32 +: 32] = $urandom;
            endcase
            case ($urandom_range(0, 3))
               0: opE[l*7 +: 7] = OP_BR;
               1: opE[l*7 +: 7] = OP_JAL;
               2: opE[l*7 +: 7] = OP_JALR;
               default: opE[l*7 +: 7] = 7'($urandom);
            endcase
         end
         misp  = 2'($urandom);
         taken = 2'($urandom);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ucsbece154b_perf_monitor.md
UCSBECE154B_PERF_MONITOR -- requirements
Module: ucsbece154b_perf_monitor

Interface
REQ-001 SHALL have parameter LANES, default 2, number of issue slots monitored (1..4).
REQ-002 SHALL have parameter CNT_W, default 32, width of every event counter.
REQ-003 SHALL have parameter MAX_CYCLES, default 500, cycle budget before timeout halt.
REQ-004 SHALL have parameter NOP, default 32'h00000013, encoding treated as non-instruction.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 enable  input  1  IDLE->RUN request.
REQ-008 clear  input  1  synchronous counter clear, return to IDLE.
REQ-009 instrF  input  LANES*32  fetch-stage instruction per lane, lane 0 in bits [31:0].
REQ-010 pcF  input  LANES*32  fetch-stage PC per lane.
REQ-011 instrD  input  LANES*32  decode-stage instruction per lane.
REQ-012 opE  input  LANES*7  execute-stage opcode per lane.
REQ-013 mispredictE  input  LANES  branch mispredict flag per lane, valid with opE.
REQ-014 takenF  input  LANES  predictor taken flag per lane, qualifies jumps.
REQ-015 rd_sel  input  3  readout select: 0 cycles, 1 instrs, 2 branches, 3 branch misses, 4 jumps, 5 jump misses, 6-7 zero.
REQ-016 rd_data  output  CNT_W  registered value of counter chosen by rd_sel.
REQ-017 state  output  2  0 IDLE, 1 RUN, 2 HALTED, 3 unused.
REQ-018 done  output  1  high in HALTED.
REQ-019 timeout  output  1  high when HALTED was entered via MAX_CYCLES.

Function
REQ-020 FSM: IDLE->RUN when enable=1; RUN->HALTED on halt condition or cycle counter reaching MAX_CYCLES; HALTED persistent until reset or clear.
REQ-021 Halt condition: every lane instrF==NOP and pcF equal to its value in the previous cycle, with prev_valid set.
REQ-022 prev_valid SHALL be 0 in the first RUN cycle and 1 thereafter, so PC compare never uses a reset value.
REQ-023 Every RUN cycle, including the halt-detect cycle, SHALL increment cycle counter by 1.
REQ-024 In non-halt RUN cycles, instruction counter SHALL add the number of lanes with instrD !=0 and !=NOP (0..LANES, single-cycle add).
REQ-025 Per lane, opE==7'b1100011 SHALL add 1 to branches and, if mispredictE, 1 to branch misses.
REQ-026 Per lane, opE==7'b1101111 or 7'b1100111 SHALL add 1 to jumps and, if takenF==0, 1 to jump misses.
REQ-027 Lane contributions SHALL be summed in one cycle; per-cycle increment up to LANES.
REQ-028 Counters SHALL saturate at 2^CNT_W-1, never wrap.
REQ-029 In IDLE and HALTED, no counter changes; values hold for readout.
REQ-030 Timeout SHALL be taken when the post-increment cycle count equals MAX_CYCLES; same-cycle halt condition sets done with timeout=0 (halt wins).
REQ-031 rd_data SHALL reflect rd_sel and counter state one cycle after sampling (1-cycle latency).
REQ-032 clear SHALL win over enable, halt and timeout in the same cycle.

Reset
REQ-033 On reset or clear: all counters 0, state IDLE, done 0, timeout 0, prev_valid 0, prev PCs 0, rd_data 0 next cycle.
REQ-034 Reset asserted mid-RUN SHALL abort counting in that cycle with no partial increment.

Verification
REQ-035 LANES=2: enable, 10 cycles both lanes instrD=ADDI, no branches -> cycles=10, instrs=20, other counters 0.
REQ-036 Lane0 opE=1100011 mispredict=1, lane1 opE=1100011 mispredict=0, one cycle -> branches=2, branch misses=1.
REQ-037 Lane1 opE=1101111 takenF=0 for 3 cycles -> jumps=3, jump misses=3.
REQ-038 Both lanes instrF=NOP, PCs constant 0x40/0x44 from RUN cycle 5 -> HALTED after cycle 6, done=1, timeout=0, counters frozen.
REQ-039 MAX_CYCLES=8, never halt -> HALTED with cycles=8, timeout=1; clear next cycle -> IDLE, all counters 0.
REQ-040 CNT_W=4, 20 cycles of 2 instrs -> instrs=15, cycles=15 saturated.
